l2_mem_fill_unit: RTL
=====================

// Module: l2_mem_fill_unit
// PURPOSE
//  Parametrised successor to the single-beat LOAD_MEM_ACK path. Tracks up to
//  MSHR_N outstanding L2 misses and assembles multi-beat memory acks on msg3.
//  For each completed line it writes the line into the L2 array (tag, vd=2'b10)
//  and then returns a data response to the requester on msg2.
//  Sits between the L2 miss pipeline (alloc), the memory return channel (msg3)
//  and the L2 data array and NoC output (msg2).
// PARAMETERS
//  TAG_W       26     tag width
//  DATA_W      64     width of one msg3 beat
//  SRC_W       6      requester id width
//  TYPE_W      8      message type width
//  BEATS       2      beats per cache line (>=1); line width = BEATS*DATA_W
//  MSHR_N      4      outstanding miss entries (>=1)
//  ACK_TYPE    8'h18  msg3 type for a memory load ack
//  RESP_TYPE   8'h19  msg2 type for a data response
// PORTS
//  clk           in   1                clock, rising edge
//  rst_n         in   1                asynchronous reset, active low
//  alloc_valid   in   1                miss pipeline requests an entry
//  alloc_ready   out  1                entry available and tag not pending
//  alloc_tag     in   TAG_W            missing line tag
//  alloc_source  in   SRC_W            requester id
//  msg3_valid    in   1                memory ack beat valid
//  msg3_ready    out  1                beat accepted
//  msg3_type     in   TYPE_W           ack type
//  msg3_tag      in   TAG_W            ack tag, matched against pending entries
//  msg3_data     in   DATA_W           beat data
//  fill_valid    out  1                array write request
//  fill_ready    in   1                array accepts write
//  fill_tag      out  TAG_W            tag to write
//  fill_vd       out  2                always 2'b10 when fill_valid
//  fill_data     out  BEATS*DATA_W     assembled line; beat 0 in LSBs
//  msg2_valid    out  1                response valid
//  msg2_ready    in   1                NoC accepts response
//  msg2_type     out  TYPE_W           RESP_TYPE when msg2_valid
//  msg2_source   out  SRC_W            requester id of the entry
//  msg2_tag      out  TAG_W            tag of the entry
//  msg2_data     out  BEATS*DATA_W     same line as fill_data
//  mshr_busy     out  MSHR_N           per-entry not-FREE flags
//  err_unexp     out  1                1-cycle pulse on an unmatched or mistyped ack
// BEHAVIOUR
//  - Reset (rst_n low, async): all entries FREE; beat counters 0; output FSM IDLE.
//    All valid/ready/busy/err outputs are 0 and all data outputs are 0.
//    msg3_ready rises on the first clk edge after rst_n deasserts.
//    Any fill or response in flight is dropped.
//  - Entry states: FREE -> WAIT (on alloc handshake; stores tag, source; cnt=0)
//    -> DONE (when beat BEATS-1 is accepted) -> FREE (on msg2 handshake).
//  - alloc_ready = rst_n & (any FREE) & no WAIT/DONE entry has tag==alloc_tag.
//    Allocation takes the lowest-index FREE entry.
//  - msg3_ready is 1 when out of reset; every beat is consumed.
//  - A beat matches when msg3_type==ACK_TYPE and a WAIT entry has the same tag.
//    A matching beat writes line[cnt*DATA_W +: DATA_W] and increments cnt.
//    Otherwise the beat is dropped and err_unexp pulses on the next cycle.
//  - Output FSM: IDLE -> FILL -> RESP -> IDLE. In IDLE it registers the
//    lowest-index DONE entry and moves to FILL. fill_valid is held until
//    fill_ready, then the FSM moves to RESP. msg2_valid is held until msg2_ready,
//    then the entry is freed and the FSM returns to IDLE.
//    Payload is stable while valid is high without ready.
//  - Latency: last beat accepted at edge N gives DONE at N+1. With the FSM idle,
//    fill_valid is high in cycle N+2. The minimum from last beat to msg2
//    handshake is 3 cycles.
//  - Simultaneous events: alloc and free in the same cycle are both honoured;
//    a freed entry is allocatable from the next cycle.
//    An alloc and a first beat with the same tag in the same cycle: the beat
//    does not match the not-yet-WAIT entry, so it is dropped with err_unexp.
//  - Pending tags are unique (enforced by alloc_ready), so at most one entry matches.
//  - BEATS==1 collapses WAIT to a single beat; cnt width is max(1,$clog2(BEATS)).
// TESTING
//  1 Alloc tag 0x123 src 5; acks 0x18/0x123 with data A then B
//    -> fill_tag 0x123, vd 2'b10, fill_data {B,A}; then msg2 type 0x19, src 5.
//  2 Fill MSHR_N entries -> alloc_ready 0; complete one response
//    -> alloc_ready 1 the next cycle.
//  3 Alloc tag 0x55 twice -> the second is refused until the first response handshakes.
//  4 Ack type 0x17, or an unknown tag -> dropped, err_unexp pulses, no entry change.
//  5 Two entries complete together; hold fill_ready and msg2_ready low for 3 cycles
//    -> lowest index is served first, payload stable, second entry follows.
//  6 Assert rst_n low during FILL -> outputs 0 immediately, mshr_busy 0;
//    msg3_ready is 1 one edge after release.

Source files
------------

// File: rtl/l2_mem_fill_unit.sv
// l2_mem_fill_unit: tracks outstanding L2 misses, assembles multi-beat memory acks,
// then writes each completed line into the array and returns it to the requester.
module l2_mem_fill_unit #(
    parameter int          TAG_W     = 26,
    parameter int          DATA_W    = 64,
    parameter int          SRC_W     = 6,
    parameter int          TYPE_W    = 8,
    parameter int          BEATS     = 2,
    parameter int          MSHR_N    = 4,
    parameter logic [7:0]  ACK_TYPE  = 8'h18,
    parameter logic [7:0]  RESP_TYPE = 8'h19
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    input  logic [TAG_W-1:0]        alloc_tag,
    input  logic [SRC_W-1:0]        alloc_source,
    input  logic                    msg3_valid,
    output logic                    msg3_ready,
    input  logic [TYPE_W-1:0]       msg3_type,
    input  logic [TAG_W-1:0]        msg3_tag,
    input  logic [DATA_W-1:0]       msg3_data,
    output logic                    fill_valid,
    input  logic                    fill_ready,
    output logic [TAG_W-1:0]        fill_tag,
    output logic [1:0]              fill_vd,
    output logic [BEATS*DATA_W-1:0] fill_data,
    output logic                    msg2_valid,
    input  logic                    msg2_ready,
    output logic [TYPE_W-1:0]       msg2_type,
    output logic [SRC_W-1:0]        msg2_source,
    output logic [TAG_W-1:0]        msg2_tag,
    output logic [BEATS*DATA_W-1:0] msg2_data,
    output logic [MSHR_N-1:0]       mshr_busy,
    output logic                    err_unexp
);
    localparam int LW = BEATS*DATA_W;
    localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int IW = MSHR_N > 1 ? $clog2(MSHR_N) : 1;
    localparam logic [1:0] E_FREE = 2'd0, E_WAIT = 2'd1, E_DONE = 2'd2;
    localparam logic [1:0] S_IDLE = 2'd0, S_FILL = 2'd1, S_RESP = 2'd2;

    logic [1:0]       est   [MSHR_N];
    logic [TAG_W-1:0] etag  [MSHR_N];
    logic [SRC_W-1:0] esrc  [MSHR_N];
    logic [CW-1:0]    ecnt  [MSHR_N];
    logic [LW-1:0]    eline [MSHR_N];

    logic [1:0]       st, st_nx;
    logic [IW-1:0]    sel, free_idx, done_idx, hit_idx;
    logic [TAG_W-1:0] out_tag;
    logic [SRC_W-1:0] out_src;
    logic [LW-1:0]    out_line;
    logic             rdy_q, err_q, any_free, any_done, tag_pend, hit;
    logic             alloc_fire, beat_ok, resp_fire;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        any_free = 1'b0;
        any_done = 1'b0;
        tag_pend = 1'b0;
        hit      = 1'b0;
        free_idx = '0;
        done_idx = '0;
        hit_idx  = '0;
        for (int i = MSHR_N-1; i >= 0; i--) begin
            if (est[i] == E_FREE) begin
                any_free = 1'b1;
                free_idx = IW'(i);
            end
            if (est[i] == E_DONE) begin
                any_done = 1'b1;
                done_idx = IW'(i);
            end
            if (est[i] != E_FREE && etag[i] == alloc_tag) tag_pend = 1'b1;
            if (est[i] == E_WAIT && etag[i] == msg3_tag) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    assign alloc_ready = rst_n & any_free & ~tag_pend;
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign beat_ok     = msg3_valid & rdy_q & (msg3_type == TYPE_W'(ACK_TYPE)) & hit;
    assign resp_fire   = msg2_valid & msg2_ready;

    // Alloc touches a FREE entry, beats a WAIT entry, free a DONE entry: never the same one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSHR_N; i++) begin
                est[i]   <= E_FREE;
                etag[i]  <= '0;
                esrc[i]  <= '0;
                ecnt[i]  <= '0;
                eline[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MSHR_N; i++) begin
                if (alloc_fire && free_idx == IW'(i)) begin
                    est[i]  <= E_WAIT;
                    etag[i] <= alloc_tag;
                    esrc[i] <= alloc_source;
                    ecnt[i] <= '0;
                end
                if (beat_ok && hit_idx == IW'(i)) begin
                    eline[i][ecnt[i]*DATA_W +: DATA_W] <= msg3_data;
                    ecnt[i] <= ecnt[i] + CW'(1);
                    if (ecnt[i] == CW'(BEATS-1)) est[i] <= E_DONE;
                end
                if (resp_fire && sel == IW'(i)) est[i] <= E_FREE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            err_q <= msg3_valid & rdy_q & ~beat_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= S_IDLE;
        else        st <= st_nx;
    end

    always_comb
        st_nx = (st == S_IDLE) ? (any_done ? S_FILL : S_IDLE) :
                (st == S_FILL) ? (fill_ready ? S_RESP : S_FILL) :
                                 (msg2_ready ? S_IDLE : S_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel      <= '0;
            out_tag  <= '0;
            out_src  <= '0;
            out_line <= '0;
        end else if (st == S_IDLE && any_done) begin
            sel      <= done_idx;
            out_tag  <= etag[done_idx];
            out_src  <= esrc[done_idx];
            out_line <= eline[done_idx];
        end
    end

    always_comb begin
        fill_valid = st == S_FILL;
        msg2_valid = st == S_RESP;
        fill_vd    = fill_valid ? 2'b10 : 2'b00;
        msg2_type  = msg2_valid ? TYPE_W'(RESP_TYPE) : '0;
        for (int i = 0; i < MSHR_N; i++) mshr_busy[i] = est[i] != E_FREE;
    end

    assign fill_tag    = out_tag;
    assign fill_data   = out_line;
    assign msg2_tag    = out_tag;
    assign msg2_source = out_src;
    assign msg2_data   = out_line;
    assign msg3_ready  = rdy_q;
    assign err_unexp   = err_q;
endmodule
